free_list: RTL and testbench

//  Circular FIFO of unallocated physical registers for the ERR-style rename

---
 rtl/free_list_if.sv | 26 ++
 rtl/free_list.sv | 89 ++++++++
 tb/tb_free_list.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename/retire-side bundle for the physical-register free list.
// The slave modport is the free list itself; master is the rename/retire logic.
interface free_list_if #(
    parameter int PHYS_WIDTH = 6,
    parameter int PTR_W      = 6
);
    logic                  deq_req;
    logic                  deq_valid;
    logic [PHYS_WIDTH-1:0] deq_preg;
    logic                  enq_en;
    logic [PHYS_WIDTH-1:0] enq_preg;
    logic                  commit_alloc;
    logic                  flush;
    logic [PTR_W-1:0]      free_count;
    logic                  overflow_err;

    modport slave (
        input  deq_req, enq_en, enq_preg, commit_alloc, flush,
        output deq_valid, deq_preg, free_count, overflow_err
    );

    modport master (
        output deq_req, enq_en, enq_preg, commit_alloc, flush,
        input  deq_valid, deq_preg, free_count, overflow_err
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers with a speculative head for rename
// and a retirement head that the speculative head snaps back to on flush.
module free_list #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int PHYS_WIDTH = $clog2(PHYS_REGS)
) (
    input logic       clk,
    input logic       rst,
    free_list_if.slave fl
);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [PHYS_WIDTH-1:0] preg_t;

    preg_t mem_q [FL_DEPTH];
    ptr_t  head_q, head_d;
    ptr_t  tail_q, tail_d;
    ptr_t  rrf_q, rrf_d;
    ptr_t  count_q, count_d;
    logic  ovf_q, ovf_d;

    logic empty, full, pop, push_req, push;

    assign empty    = (head_q == tail_q);
    assign full     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                      (head_q[PTR_W-1] != tail_q[PTR_W-1]);
    assign pop      = fl.deq_req && !empty && !fl.flush;
    assign push_req = fl.enq_en && (fl.enq_preg != '0);
    // A pop frees the slot at tail when full, so the push can land there.
    assign push     = push_req && (!full || pop);

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        rrf_d   = rrf_q + ptr_t'(fl.commit_alloc);
        ovf_d   = ovf_q;
        if (fl.flush)
            head_d = rrf_q + ptr_t'(fl.commit_alloc);
        else if (pop)
            head_d = head_q + ptr_t'(1);
        if (push)
            tail_d = tail_q + ptr_t'(1);
        if (push_req && full && !pop)
            ovf_d = 1'b1;
        count_d = tail_d - head_d;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            rrf_q   <= '0;
            tail_q  <= ptr_t'(FL_DEPTH);
            count_q <= ptr_t'(FL_DEPTH);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            rrf_q   <= rrf_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: the storage is reset on purpose: it must hold the initial pool ARCH_REGS.. after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++)
                mem_q[i] <= preg_t'(ARCH_REGS + i);
        end else if (push) begin
            mem_q[tail_q[IDX_W-1:0]] <= fl.enq_preg;
        end
    end

    assign fl.deq_valid    = !empty;
    assign fl.deq_preg     = mem_q[head_q[IDX_W-1:0]];
    assign fl.free_count   = count_q;
    assign fl.overflow_err = ovf_q;

    // Retirement can only commit allocations rename has already made.
    assert property (@(posedge clk) disable iff (!rst)
        fl.commit_alloc |-> (rrf_q != head_q))
    else $error("free_list: retirement head passed speculative head");
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, drain, recycle, flush recovery and full/wrap.
module tb_free_list;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    free_list_if #(.PHYS_WIDTH(6), .PTR_W(6)) fl_if ();

    free_list #(.ARCH_REGS(32), .PHYS_REGS(64), .PHYS_WIDTH(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    task automatic idle_inputs();
        fl_if.deq_req      = 1'b0;
        fl_if.enq_en       = 1'b0;
        fl_if.enq_preg     = '0;
        fl_if.commit_alloc = 1'b0;
        fl_if.flush        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fl_if.deq_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_deq_valid: got %0b want 1", fl_if.deq_valid);
        end
        n_checks++;
        if (fl_if.deq_preg !== 6'd32) begin
            n_fail++; $display("FAIL reset_deq_preg: got %0d want 32", fl_if.deq_preg);
        end
        n_checks++;
        if (fl_if.free_count !== 6'd32) begin
            n_fail++; $display("FAIL reset_free_count: got %0d want 32", fl_if.free_count);
        end
        n_checks++;
        if (fl_if.overflow_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %0b want 0", fl_if.overflow_err);
        end
    endtask

    task automatic test_drain();
        do_reset();
        fl_if.deq_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (fl_if.deq_valid !== 1'b1 || fl_if.deq_preg !== 6'(32 + i)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got valid=%0b preg=%0d want valid=1 preg=%0d",
                         i, fl_if.deq_valid, fl_if.deq_preg, 32 + i);
            end
            step();
        end
        n_checks++;
        if (fl_if.deq_valid !== 1'b0 || fl_if.free_count !== 6'd0) begin
            n_fail++;
            $display("FAIL drain_empty: got valid=%0b count=%0d want valid=0 count=0",
                     fl_if.deq_valid, fl_if.free_count);
        end
        step();
        n_checks++;
        if (fl_if.deq_valid !== 1'b0 || fl_if.free_count !== 6'd0) begin
            n_fail++;
            $display("FAIL drain_extra_deq: got valid=%0b count=%0d want valid=0 count=0",
                     fl_if.deq_valid, fl_if.free_count);
        end
        fl_if.deq_req = 1'b0;
    endtask

    // Runs from the empty state left by test_drain.
    task automatic test_recycle();
        fl_if.enq_en   = 1'b1;
        fl_if.enq_preg = 6'd5;
        n_checks++;
        if (fl_if.deq_valid !== 1'b0) begin
            n_fail++; $display("FAIL recycle_no_bypass: got valid=%0b want 0", fl_if.deq_valid);
        end
        step();
        fl_if.enq_preg = 6'd0;
        n_checks++;
        if (fl_if.deq_valid !== 1'b1 || fl_if.deq_preg !== 6'd5 || fl_if.free_count !== 6'd1) begin
            n_fail++;
            $display("FAIL recycle_push: got valid=%0b preg=%0d count=%0d want 1/5/1",
                     fl_if.deq_valid, fl_if.deq_preg, fl_if.free_count);
        end
        step();
        fl_if.enq_en = 1'b0;
        n_checks++;
        if (fl_if.free_count !== 6'd1 || fl_if.deq_preg !== 6'd5) begin
            n_fail++;
            $display("FAIL recycle_zero_noop: got count=%0d preg=%0d want 1/5",
                     fl_if.free_count, fl_if.deq_preg);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fl_if.deq_req = 1'b1;
        repeat (3) step();
        fl_if.deq_req = 1'b0;
        n_checks++;
        if (fl_if.deq_preg !== 6'd35 || fl_if.free_count !== 6'd29) begin
            n_fail++;
            $display("FAIL flush_pre: got preg=%0d count=%0d want 35/29",
                     fl_if.deq_preg, fl_if.free_count);
        end
        fl_if.commit_alloc = 1'b1;
        step();
        fl_if.commit_alloc = 1'b0;
        fl_if.flush        = 1'b1;
        fl_if.deq_req      = 1'b1;
        step();
        idle_inputs();
        n_checks++;
        if (fl_if.deq_preg !== 6'd33 || fl_if.free_count !== 6'd31) begin
            n_fail++;
            $display("FAIL flush_recover: got preg=%0d count=%0d want 33/31",
                     fl_if.deq_preg, fl_if.free_count);
        end
    endtask

    task automatic test_flush_commit_enq();
        do_reset();
        fl_if.deq_req = 1'b1;
        repeat (4) step();
        fl_if.deq_req      = 1'b0;
        fl_if.commit_alloc = 1'b1;
        step();
        fl_if.flush    = 1'b1;
        fl_if.enq_en   = 1'b1;
        fl_if.enq_preg = 6'd7;
        step();
        idle_inputs();
        n_checks++;
        if (fl_if.deq_preg !== 6'd34 || fl_if.free_count !== 6'd31) begin
            n_fail++;
            $display("FAIL fce_recover: got preg=%0d count=%0d want 34/31",
                     fl_if.deq_preg, fl_if.free_count);
        end
        fl_if.deq_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if (fl_if.deq_preg !== 6'(34 + i)) begin
                n_fail++;
                $display("FAIL fce_order[%0d]: got %0d want %0d", i, fl_if.deq_preg, 34 + i);
            end
            step();
        end
        fl_if.deq_req = 1'b0;
        n_checks++;
        if (fl_if.deq_valid !== 1'b1 || fl_if.deq_preg !== 6'd7 || fl_if.free_count !== 6'd1) begin
            n_fail++;
            $display("FAIL fce_enq_entry: got valid=%0b preg=%0d count=%0d want 1/7/1",
                     fl_if.deq_valid, fl_if.deq_preg, fl_if.free_count);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        fl_if.enq_en   = 1'b1;
        fl_if.enq_preg = 6'd9;
        step();
        fl_if.enq_en = 1'b0;
        n_checks++;
        if (fl_if.overflow_err !== 1'b1 || fl_if.free_count !== 6'd32 || fl_if.deq_preg !== 6'd32) begin
            n_fail++;
            $display("FAIL full_overflow: got ovf=%0b count=%0d preg=%0d want 1/32/32",
                     fl_if.overflow_err, fl_if.free_count, fl_if.deq_preg);
        end
        fl_if.deq_req = 1'b1;
        fl_if.enq_en  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            fl_if.enq_preg = 6'(i + 1);
            n_checks++;
            if (fl_if.deq_preg !== ((i < 32) ? 6'(32 + i) : 6'(i - 31))) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %0d want %0d", i, fl_if.deq_preg,
                         (i < 32) ? 32 + i : i - 31);
            end
            step();
            n_checks++;
            if (fl_if.free_count !== 6'd32) begin
                n_fail++;
                $display("FAIL wrap_count[%0d]: got %0d want 32", i, fl_if.free_count);
            end
        end
        idle_inputs();
        n_checks++;
        if (fl_if.overflow_err !== 1'b1 || fl_if.deq_preg !== 6'd9) begin
            n_fail++;
            $display("FAIL wrap_sticky: got ovf=%0b preg=%0d want 1/9",
                     fl_if.overflow_err, fl_if.deq_preg);
        end
        do_reset();
        n_checks++;
        if (fl_if.overflow_err !== 1'b0 || fl_if.deq_preg !== 6'd32 || fl_if.free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL midop_reset: got ovf=%0b preg=%0d count=%0d want 0/32/32",
                     fl_if.overflow_err, fl_if.deq_preg, fl_if.free_count);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_drain();
        test_recycle();
        test_flush();
        test_flush_commit_enq();
        test_full_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
